// File: rtl/bp_cfg_sequencer.sv
// Boot-time config-bus master: walks an (addr, data) table and writes every entry to
// every core over a valid/ready cfg link, once per start_i.
// Optional feature: define BP_CFG_SEQ_BROADCAST_EN to issue each entry once to the
// broadcast core id (all-ones) instead of looping over cores.
module bp_cfg_sequencer #(
  parameter int unsigned num_core_p       = 1,
  parameter int unsigned cfg_core_width_p = 8,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 32,
  parameter int unsigned num_cfg_els_p    = 16,
  localparam int unsigned IdxW = (num_cfg_els_p > 1) ? $clog2(num_cfg_els_p) : 1,
  localparam int unsigned RomW = cfg_addr_width_p + cfg_data_width_p
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic [IdxW-1:0]             rom_idx_o,
  input  logic [RomW-1:0]             rom_data_i,
  output logic                        cfg_v_o,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e                      state_q;
  logic [IdxW-1:0]             ent_q;
  logic [cfg_core_width_p-1:0] core_q;
  // Set once the final table entry of the final core has been fetched; the sequence
  // then only has to drain the beat currently held on the link.
  logic                        fetched_all_q;
  logic                        v_q;
  logic [cfg_core_width_p-1:0] core_out_q;
  logic [cfg_addr_width_p-1:0] addr_q;
  logic [cfg_data_width_p-1:0] data_q;
  logic                        busy_q;
  logic                        done_q;

  logic [cfg_addr_width_p-1:0] rom_addr;
  logic [cfg_data_width_p-1:0] rom_data;
  logic                        is_term;
  logic                        last_ent;
  logic                        last_core;
  logic [cfg_core_width_p-1:0] core_id;
  logic                        can_load;
  logic                        start_ok;
  logic                        do_fetch;

  assign rom_idx_o = ent_q;

  // Decode the entry currently addressed by the table index.
  always_comb begin
    rom_addr = rom_data_i[RomW-1 -: cfg_addr_width_p];
    rom_data = rom_data_i[cfg_data_width_p-1:0];
    is_term  = &rom_addr;
    last_ent = (ent_q == IdxW'(num_cfg_els_p - 1));
`ifdef BP_CFG_SEQ_BROADCAST_EN
    last_core = 1'b1;
    core_id   = '1;
`else
    last_core = (core_q == cfg_core_width_p'(num_core_p - 1));
    core_id   = core_q;
`endif
  end

  // Fetch a new entry when starting, or in ISSUE once the output slot is free.
  always_comb begin
    can_load = ~v_q | cfg_ready_i;
    start_ok = ((state_q == StIdle) || (state_q == StDone)) && start_i;
    do_fetch = start_ok || ((state_q == StIssue) && can_load && !fetched_all_q);
  end

  // Sequencer FSM with registered link outputs and status flags.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= StIdle;
      ent_q         <= '0;
      core_q        <= '0;
      fetched_all_q <= 1'b0;
      v_q           <= 1'b0;
      core_out_q    <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q       <= StIssue;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            fetched_all_q <= 1'b0;
          end
        end
        StIssue: begin
          // Last beat accepted (or only a terminator bubble pending): finish.
          if (can_load && fetched_all_q) begin
            state_q       <= StDone;
            busy_q        <= 1'b0;
            done_q        <= 1'b1;
            v_q           <= 1'b0;
            fetched_all_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          v_q     <= 1'b0;
        end
      endcase

      if (do_fetch) begin
        // A terminator is not issued; it leaves a one-cycle bubble on the link.
        v_q <= ~is_term;
        if (!is_term) begin
          core_out_q <= core_id;
          addr_q     <= rom_addr;
          data_q     <= rom_data;
        end
        if (is_term || last_ent) begin
          ent_q <= '0;
          if (last_core) begin
            core_q        <= '0;
            fetched_all_q <= 1'b1;
          end else begin
            core_q <= core_q + 1'b1;
          end
        end else begin
          ent_q <= ent_q + 1'b1;
        end
      end
    end
  end

  assign cfg_v_o    = v_q;
  assign cfg_core_o = core_out_q;
  assign cfg_addr_o = addr_q;
  assign cfg_data_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule
